// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-side types and constants for pc_sequencer
package cpu_pkg;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } pc_seq_state_t;

  localparam int PC_INCR    = 4;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - next-PC select: PC+4 or PC+4 plus word-scaled signed offset
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int OFFSET_W = 8
) (
  input  logic [PC_W-1:0]     i_pc,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic                i_taken,
  output logic [PC_W-1:0]     o_next_pc
);
  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_offset_ext;
  logic [PC_W-1:0] w_byte_offset;

  assign w_seq_pc      = i_pc + PC_W'(PC_INCR);
  assign w_offset_ext  = {{(PC_W-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
  assign w_byte_offset = w_offset_ext << WORD_SHIFT;
  // Modulo-2^PC_W wrap falls out of the fixed-width adds.
  assign o_next_pc     = i_taken ? (w_seq_pc + w_byte_offset) : w_seq_pc;
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter FSM (BOOT/FETCH/STALL); PC_SEQ_STALL_COUNT_EN adds STALL_CYCLES
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              OFFSET_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUSYWAIT,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [PC_W-1:0]     PC,
  output logic                INSTR_READ,
  output logic                FLUSH,
`ifdef PC_SEQ_STALL_COUNT_EN
  output logic                STALLED,
  output logic [15:0]         STALL_CYCLES
`else
  output logic                STALLED
`endif
);
  pc_seq_state_t   r_state;
  pc_seq_state_t   w_state_next;
  logic [PC_W-1:0] r_pc;
  logic            r_instr_read;
  logic            r_flush;
  logic            r_stalled;

  logic            w_taken;
  logic            w_advance;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_next;
  logic            w_instr_read_next;
  logic            w_flush_next;
  logic            w_stalled_next;

  assign w_taken   = JUMP | (BRANCH & ZERO);
  assign w_advance = (r_state != BOOT) && !BUSYWAIT;

  branch_target_calc #(
    .PC_W     (PC_W),
    .OFFSET_W (OFFSET_W)
  ) u_target (
    .i_pc      (r_pc),
    .i_offset  (OFFSET),
    .i_taken   (w_taken),
    .o_next_pc (w_target)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_instr_read <= 1'b0;
      r_flush      <= 1'b0;
      r_stalled    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_instr_read <= w_instr_read_next;
      r_flush      <= w_flush_next;
      r_stalled    <= w_stalled_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = FETCH;
      FETCH:   w_state_next = BUSYWAIT ? STALL : FETCH;
      STALL:   w_state_next = BUSYWAIT ? STALL : FETCH;
      default: w_state_next = BOOT;
    endcase
  end

  // Outputs are registered: this block computes their values for the next edge.
  always_comb begin
    w_pc_next         = r_pc;
    w_flush_next      = 1'b0;
    w_instr_read_next = (w_state_next != BOOT);
    w_stalled_next    = (w_state_next == STALL);
    if (w_advance) begin
      w_pc_next    = w_target;
      w_flush_next = w_taken;
    end
  end

`ifdef PC_SEQ_STALL_COUNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cycles <= '0;
    end else if ((r_state == STALL) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign STALL_CYCLES = r_stall_cycles;
`endif

  assign PC         = r_pc;
  assign INSTR_READ = r_instr_read;
  assign FLUSH      = r_flush;
  assign STALLED    = r_stalled;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer; honours PC_SEQ_STALL_COUNT_EN
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        BUSYWAIT = 1'b0;
  logic        JUMP = 1'b0;
  logic        BRANCH = 1'b0;
  logic        ZERO = 1'b0;
  logic [7:0]  OFFSET = 8'h00;
  logic [31:0] pc_a, pc_b;
  logic        rd_a, rd_b, fl_a, fl_b, st_a, st_b;
`ifdef PC_SEQ_STALL_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  always #5 CLK = ~CLK;

  pc_sequencer #(.PC_W(32), .OFFSET_W(8), .RESET_PC(32'h0000_0000)) dut_a (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .PC(pc_a), .INSTR_READ(rd_a), .FLUSH(fl_a),
`ifdef PC_SEQ_STALL_COUNT_EN
    .STALLED(st_a), .STALL_CYCLES(cnt_a)
`else
    .STALLED(st_a)
`endif
  );

  // Same stimulus from a reset PC of FFFF_FFFC: its first advance must wrap to 0.
  pc_sequencer #(.PC_W(32), .OFFSET_W(8), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .PC(pc_b), .INSTR_READ(rd_b), .FLUSH(fl_b),
`ifdef PC_SEQ_STALL_COUNT_EN
    .STALLED(st_b), .STALL_CYCLES(cnt_b)
`else
    .STALLED(st_b)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        rd;
    logic        fl;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference state: PC is a byte offset, stalls tracked as a simple flag.
  logic [31:0] m_pc = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_stalled = 1'b0;
  bit          m_flush = 1'b0;
  bit          m_rd = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit busy, input bit j, input bit b,
                            input bit z, input logic [7:0] off);
    int  sx;
    bit  tk;
    if (rst) begin
      m_pc = 32'h0; m_boot = 1; m_stalled = 0; m_flush = 0; m_rd = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_rd = 1; m_flush = 0;
    end else begin
      if (m_stalled && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (busy) begin
        m_stalled = 1; m_flush = 0;
      end else begin
        m_stalled = 0;
        tk = j | (b & z);
        sx = int'($signed(off));
        m_pc = m_pc + 32'(4 + (tk ? 4 * sx : 0));
        m_flush = tk;
      end
    end
  endtask

  task automatic step(input bit rst, input bit busy, input bit j, input bit b,
                      input bit z, input logic [7:0] off);
    exp_t e;
    RESET = rst; BUSYWAIT = busy; JUMP = j; BRANCH = b; ZERO = z; OFFSET = off;
    @(posedge CLK);
    #1;
    model_edge(rst, busy, j, b, z, off);
    e.pc = m_pc; e.rd = m_rd; e.fl = m_flush; e.st = m_stalled; e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc_a, e.pc);
        chk("pc_wrap", pc_b, e.pc + 32'hFFFF_FFFC);
        chk("instr_read", {31'b0, rd_a}, {31'b0, e.rd});
        chk("flush", {31'b0, fl_a}, {31'b0, e.fl});
        chk("stalled", {31'b0, st_a}, {31'b0, e.st});
        chk("stalled_b", {31'b0, st_b}, {31'b0, e.st});
`ifdef PC_SEQ_STALL_COUNT_EN
        chk("stall_cycles", {16'b0, cnt_a}, {16'b0, e.cnt});
`endif
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);                  // BOOT edge
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 1, 8'hFE);                  // 0x10 -> 0x0C taken branch
    step(0, 0, 0, 1, 0, 8'hFE);                  // not taken
    step(0, 0, 1, 0, 0, 8'h03);                  // jump
    step(0, 0, 1, 1, 0, 8'h03);                  // jump+branch, back-to-back flush
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, i[0], 0, 0, 8'h05);
    step(0, 0, 0, 0, 0, 8'h05);                  // stall release, sequential
    step(0, 1, 1, 0, 0, 8'h10);
    step(0, 1, 0, 0, 0, 8'h10);
    step(1, 1, 1, 1, 1, 8'h10);                  // reset mid-stall
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 8'($urandom()));
    end
    RESET = 1'b0; BUSYWAIT = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
